instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage with an IF/ID pipeline register. Fetches one
//   16-bit word per cycle from a synchronous-read-free instruction memory
//   (addr is the PC, instr is valid before the next rising edge). The
//   per-edge priority is reset > branch_taken > stall > normal fetch.
//   Fetching a word whose opcode matches HLT_OPCODE parks the stage in HALTED.
//   Only a branch (wrong-path halt cancel) or a reset leaves HALTED.
//
// Parameters
//   RESET_VECTOR   : PC value loaded on reset
//   HLT_OPCODE     : instr[15:12] value that halts fetch
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   instr          in   word returned by instruction memory for addr
//   stall          in   downstream not ready; hold PC and IF/ID
//   branch_taken   in   redirect to branch_target and flush IF/ID
//   branch_target  in   redirect word address
//   addr           out  instruction memory word address (the PC)
//   rd_en          out  instruction memory read enable
//   if_id_instr    out  registered fetched instruction
//   if_id_pc_plus1 out  registered address of fetched instruction + 1
//   if_id_valid    out  IF/ID holds a real instruction
//   halted         out  high while in HALTED state
//   fetch_cnt      out  saturating count of instructions captured into IF/ID
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE   = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] addr,
    output logic        rd_en,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus1,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] fetch_cnt
);

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [15:0] pc_r, pc_nxt_s;
    logic [15:0] instr_r, instr_nxt_s;
    logic [15:0] pcp1_r, pcp1_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic [15:0] cnt_r, cnt_nxt_s;
    logic [15:0] pc_plus1_s;

    // PC+1 wraps naturally modulo 2^16
    assign pc_plus1_s = pc_r + 16'h0001;

    // Next-state and next-register computation in priority order
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        instr_nxt_s = instr_r;
        pcp1_nxt_s  = pcp1_r;
        valid_nxt_s = valid_r;
        cnt_nxt_s   = cnt_r;
        if (branch_taken) begin
            // Redirect overrides stall; pc_plus1 and count are left alone
            pc_nxt_s    = branch_target;
            instr_nxt_s = 16'h0000;
            valid_nxt_s = 1'b0;
            state_nxt_s = FETCH;
        end else if (stall) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                FETCH: begin
                    instr_nxt_s = instr;
                    pcp1_nxt_s  = pc_plus1_s;
                    valid_nxt_s = 1'b1;
                    if (cnt_r != 16'hFFFF) begin
                        cnt_nxt_s = cnt_r + 16'h0001;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                    // A halt holds the PC on the HLT word itself
                    if (instr[15:12] == HLT_OPCODE) begin
                        state_nxt_s = HALTED;
                    end else begin
                        pc_nxt_s = pc_plus1_s;
                    end
                end
                HALTED: begin
                    valid_nxt_s = 1'b0;
                end
                default: begin
                    state_nxt_s = FETCH;
                end
            endcase
        end
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH;
            pc_r    <= RESET_VECTOR;
            instr_r <= 16'h0000;
            pcp1_r  <= 16'h0000;
            valid_r <= 1'b0;
            cnt_r   <= 16'h0000;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            instr_r <= instr_nxt_s;
            pcp1_r  <= pcp1_nxt_s;
            valid_r <= valid_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign addr           = pc_r;
    // rd_en drops combinationally with rst so no read is issued during reset
    assign rd_en          = (state_r == FETCH) && !rst;
    assign if_id_instr    = instr_r;
    assign if_id_pc_plus1 = pcp1_r;
    assign if_id_valid    = valid_r;
    assign halted         = (state_r == HALTED);
    assign fetch_cnt      = cnt_r;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] addr;
    logic        rd_en;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_cnt;

    instr_fetch dut (
        .clk(clk), .rst(rst), .instr(instr), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .addr(addr), .rd_en(rd_en), .if_id_instr(if_id_instr),
        .if_id_pc_plus1(if_id_pc_plus1), .if_id_valid(if_id_valid),
        .halted(halted), .fetch_cnt(fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory
    logic [15:0] mem [0:65535];

    // Reference model state (architectural view of the fetch stage)
    logic [15:0] m_pc, m_instr, m_pcp1, m_cnt;
    logic        m_valid, m_halted;
    logic        model_ok;

    int total;
    int passed;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Apply rules of one rising edge to the model
    task automatic model_edge(input logic r, input logic s, input logic b, input logic [15:0] t);
        logic [15:0] w;
        if (r) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_pcp1 = 16'h0000;
            m_valid = 1'b0; m_cnt = 16'h0000; m_halted = 1'b0;
        end else if (b) begin
            m_pc = t; m_instr = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
        end else if (s) begin
            m_pc = m_pc;
        end else if (!m_halted) begin
            w = mem[m_pc];
            m_instr = w;
            m_pcp1  = 16'((32'(m_pc) + 32'd1) % 32'd65536);
            m_valid = 1'b1;
            if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (w[15:12] == 4'hF) m_halted = 1'b1;
            else m_pc = m_pcp1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // One clock cycle: drive at negedge, check pre-edge, clock, check post-edge
    task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
        @(negedge clk);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        instr = mem[addr];
        #1;
        if (model_ok) begin
            check("pre_addr", addr, m_pc);
            check("pre_rd_en", {15'd0, rd_en}, {15'd0, !m_halted && !r});
        end
        @(posedge clk);
        model_edge(r, s, b, t);
        if (r) model_ok = 1'b1;
        #1;
        if (model_ok) begin
            check("addr", addr, m_pc);
            check("if_id_instr", if_id_instr, m_instr);
            check("if_id_pc_plus1", if_id_pc_plus1, m_pcp1);
            check("if_id_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
            check("halted", {15'd0, halted}, {15'd0, m_halted});
            check("fetch_cnt", fetch_cnt, m_cnt);
            check("rd_en", {15'd0, rd_en}, {15'd0, !m_halted && !r});
        end
    endtask

    typedef struct {
        logic        rst, stall, br;
        logic [15:0] tgt;
        logic [15:0] e_instr, e_pcp1;
        logic        e_valid;
        logic [15:0] e_addr, e_cnt;
        logic        e_halted, e_rd;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [15:0] t,
                                input logic [15:0] ei, input logic [15:0] ep, input logic ev,
                                input logic [15:0] ea, input logic [15:0] ec, input logic eh,
                                input logic erd);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t;
        v.e_instr = ei; v.e_pcp1 = ep; v.e_valid = ev; v.e_addr = ea;
        v.e_cnt = ec; v.e_halted = eh; v.e_rd = erd;
        return v;
    endfunction

    initial begin
        total = 0; passed = 0; model_ok = 1'b0;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000; instr = 16'h0000;
        m_pc = 16'h0000; m_instr = 16'h0000; m_pcp1 = 16'h0000;
        m_valid = 1'b0; m_cnt = 16'h0000; m_halted = 1'b0;

        for (int i = 0; i < 65536; i++) mem[i] = 16'h0123;
        mem[16'h0000] = 16'h1000; mem[16'h0001] = 16'h2001;
        mem[16'h0002] = 16'h3002; mem[16'h0003] = 16'h4003;
        mem[16'h0004] = 16'h5004; mem[16'h0005] = 16'hF000;
        mem[16'h0010] = 16'h1010; mem[16'h0040] = 16'h2040;
        mem[16'hFFFF] = 16'h1234;

        //             rst   stall br    tgt       instr     pcp1      vld   addr      cnt       hlt   rd
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'd0,  1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1000, 16'h0001, 1'b1, 16'h0001, 16'd1,  1'b0, 1'b1);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h2001, 16'h0002, 1'b1, 16'h0002, 16'd2,  1'b0, 1'b1);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h2001, 16'h0002, 1'b1, 16'h0002, 16'd2,  1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h2001, 16'h0002, 1'b1, 16'h0002, 16'd2,  1'b0, 1'b1);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h3002, 16'h0003, 1'b1, 16'h0003, 16'd3,  1'b0, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h4003, 16'h0004, 1'b1, 16'h0004, 16'd4,  1'b0, 1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h5004, 16'h0005, 1'b1, 16'h0005, 16'd5,  1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'hF000, 16'h0006, 1'b1, 16'h0005, 16'd6,  1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'hF000, 16'h0006, 1'b0, 16'h0005, 16'd6,  1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h0006, 1'b0, 16'h0010, 16'd6,  1'b0, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1010, 16'h0011, 1'b1, 16'h0011, 16'd7,  1'b0, 1'b1);
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'h0011, 1'b0, 16'h0040, 16'd7,  1'b0, 1'b1);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h2040, 16'h0041, 1'b1, 16'h0041, 16'd8,  1'b0, 1'b1);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0041, 1'b0, 16'hFFFF, 16'd8,  1'b0, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 1'b1, 16'h0000, 16'd9,  1'b0, 1'b1);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1000, 16'h0001, 1'b1, 16'h0001, 16'd10, 1'b0, 1'b1);
        vecs[17] = mk(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000, 16'h0001, 1'b0, 16'h0005, 16'd10, 1'b0, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'hF000, 16'h0006, 1'b1, 16'h0005, 16'd11, 1'b1, 1'b0);
        vecs[19] = mk(1'b1, 1'b1, 1'b1, 16'h0100, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'd0,  1'b0, 1'b0);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1000, 16'h0001, 1'b1, 16'h0001, 16'd1,  1'b0, 1'b1);

        // Directed table: sequential fetch, stall, branch-in-stall, halt, wrap, reset
        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
            check($sformatf("v%0d_instr", i), if_id_instr, vecs[i].e_instr);
            check($sformatf("v%0d_pcp1", i), if_id_pc_plus1, vecs[i].e_pcp1);
            check($sformatf("v%0d_valid", i), {15'd0, if_id_valid}, {15'd0, vecs[i].e_valid});
            check($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
            check($sformatf("v%0d_cnt", i), fetch_cnt, vecs[i].e_cnt);
            check($sformatf("v%0d_halted", i), {15'd0, halted}, {15'd0, vecs[i].e_halted});
            check($sformatf("v%0d_rd_en", i), {15'd0, rd_en}, {15'd0, vecs[i].e_rd});
        end

        // Hand sequence: stall while halted holds everything, including valid
        step(1'b0, 1'b0, 1'b1, 16'h0005);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        check("halt_stall_valid", {15'd0, if_id_valid}, 16'd1);
        check("halt_stall_halted", {15'd0, halted}, 16'd1);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check("halt_release_valid", {15'd0, if_id_valid}, 16'd0);

        // Randomized phase against the reference model
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 16'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
